// File: rtl/uart_tx_buf.sv
`default_nettype none
// ============================================================================
// Module  : uart_tx_buf
// Brief   : Buffered 8N1 UART transmitter with a small byte FIFO, LSB first.
// Revision: 1.0 - initial release
// ============================================================================
module uart_tx_buf #(
    parameter int CLOCK_RATE = 125_000_000,
    parameter int BAUD_RATE  = 115_200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk_tx,
    input  logic                          rst_clk_tx_n,
    input  logic [7:0]                    tx_data,
    input  logic                          tx_data_rdy,
    output logic                          txd_tx,
    output logic                          tx_busy,
    output logic                          fifo_full,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          tx_ovf
);

    localparam int BAUD_DIV = (CLOCK_RATE + BAUD_RATE / 2) / BAUD_RATE;
    localparam int BW       = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam int PW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW       = $clog2(FIFO_DEPTH) + 1;

    localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] DEPTH     = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t         state;
    logic [7:0]     mem [FIFO_DEPTH];
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic [BW-1:0]  baud_cnt;
    logic [2:0]     bit_cnt;
    logic [7:0]     shift;

    logic           baud_last;
    logic           not_empty;
    logic           pop;
    logic           wr;
    logic           busy_nxt;
    logic [CW-1:0]  count_nxt;

    assign baud_last = (baud_cnt == BAUD_LAST);
    assign not_empty = (fifo_count != '0);

    // The head leaves the FIFO either from idle or on the very last stop clock,
    // which is what makes back-to-back frames contiguous.
    assign pop = not_empty && ((state == IDLE) || ((state == STOP) && baud_last));
    assign wr  = tx_data_rdy && (!fifo_full || pop);

    always_comb begin
        count_nxt = fifo_count;
        case ({wr, pop})
            2'b10:   count_nxt = fifo_count + 1'b1;
            2'b01:   count_nxt = fifo_count - 1'b1;
            default: count_nxt = fifo_count;
        endcase
    end

    assign busy_nxt = pop || (count_nxt != '0) ||
                      ((state != IDLE) && !((state == STOP) && baud_last));

    always_ff @(posedge clk_tx) begin
        if (wr) begin
            mem[wr_ptr] <= tx_data;
        end
    end

    always_ff @(posedge clk_tx or negedge rst_clk_tx_n) begin
        if (!rst_clk_tx_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            fifo_full  <= 1'b0;
            tx_ovf     <= 1'b0;
        end else begin
            if (wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            fifo_count <= count_nxt;
            fifo_full  <= (count_nxt == DEPTH);
            tx_ovf     <= tx_data_rdy && !wr;
        end
    end

    always_ff @(posedge clk_tx or negedge rst_clk_tx_n) begin
        if (!rst_clk_tx_n) begin
            state    <= IDLE;
            txd_tx   <= 1'b1;
            tx_busy  <= 1'b0;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
        end else begin
            tx_busy <= busy_nxt;
            case (state)
                IDLE: begin
                    txd_tx <= 1'b1;
                    if (pop) begin
                        shift    <= mem[rd_ptr];
                        bit_cnt  <= '0;
                        baud_cnt <= '0;
                        txd_tx   <= 1'b0;
                        state    <= START;
                    end
                end
                START: begin
                    if (baud_last) begin
                        baud_cnt <= '0;
                        txd_tx   <= shift[0];
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (baud_last) begin
                        baud_cnt <= '0;
                        shift    <= {1'b0, shift[7:1]};
                        if (bit_cnt == 3'd7) begin
                            txd_tx <= 1'b1;
                            state  <= STOP;
                        end else begin
                            txd_tx  <= shift[1];
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (baud_last) begin
                        baud_cnt <= '0;
                        if (pop) begin
                            shift   <= mem[rd_ptr];
                            bit_cnt <= '0;
                            txd_tx  <= 1'b0;
                            state   <= START;
                        end else begin
                            txd_tx <= 1'b1;
                            state  <= IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: begin
                    txd_tx <= 1'b1;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_buf.sv
`default_nettype none
// ============================================================================
// Module  : tb_uart_tx_buf
// Brief   : Randomized self-checking bench for uart_tx_buf against a frame-level model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_uart_tx_buf;

    localparam int DEPTH  = 4;
    localparam int BD     = 10;          // (1000 + 50) / 100
    localparam int FRAME  = 10 * BD;
    localparam int DEF_BD = 1085;        // (125e6 + 57600) / 115200

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] tx_data;
    logic       tx_data_rdy;
    logic       txd, busy, full, ovf;
    logic [2:0] count;

    logic [7:0] d_data;
    logic       d_rdy;
    logic       d_txd, d_busy, d_full, d_ovf;
    logic [2:0] d_count;

    always #5 clk = ~clk;

    uart_tx_buf #(.CLOCK_RATE(1000), .BAUD_RATE(100), .FIFO_DEPTH(DEPTH)) dut (
        .clk_tx(clk), .rst_clk_tx_n(rst_n), .tx_data(tx_data), .tx_data_rdy(tx_data_rdy),
        .txd_tx(txd), .tx_busy(busy), .fifo_full(full), .fifo_count(count), .tx_ovf(ovf)
    );

    uart_tx_buf dut_def (
        .clk_tx(clk), .rst_clk_tx_n(rst_n), .tx_data(d_data), .tx_data_rdy(d_rdy),
        .txd_tx(d_txd), .tx_busy(d_busy), .fifo_full(d_full), .fifo_count(d_count), .tx_ovf(d_ovf)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got=%0h exp=%0h", tag, $time, got, exp);
        end
    endtask

    // Frame-level reference: a byte queue plus the cycle span of the frame on the line.
    logic [7:0] mq[$];
    logic [7:0] exp_rx[$];
    logic [7:0] rx_q[$];
    logic [7:0] m_fb;
    int         m_t, m_fs, m_fe;
    bit         m_ovf;
    bit         rx_on, rx_busy;

    function automatic bit in_frame();
        return (m_t >= m_fs) && (m_t <= m_fe);
    endfunction

    function automatic logic exp_txd();
        int idx;
        if (!in_frame()) return 1'b1;
        idx = (m_t - m_fs) / BD;
        if (idx == 0) return 1'b0;
        if (idx == 9) return 1'b1;
        return m_fb[idx-1];
    endfunction

    task automatic model_edge(input bit rdy, input logic [7:0] d);
        bit pop, acc;
        pop = (mq.size() != 0) && (m_t >= m_fe);
        if (pop) begin
            m_fb = mq.pop_front();
            m_fs = m_t + 1;
            m_fe = m_t + FRAME;
            if (rx_on) exp_rx.push_back(m_fb);
        end
        acc = rdy && (mq.size() < DEPTH);
        if (acc) mq.push_back(d);
        m_ovf = rdy && !acc;
        m_t++;
    endtask

    task automatic model_reset();
        mq.delete();
        m_fs  = 0;
        m_fe  = -1;
        m_ovf = 1'b0;
    endtask

    task automatic compare_all();
        chk("txd",   txd,   exp_txd());
        chk("busy",  busy,  in_frame() || (mq.size() != 0));
        chk("count", count, mq.size());
        chk("full",  full,  mq.size() == DEPTH);
        chk("ovf",   ovf,   m_ovf);
    endtask

    task automatic cyc(input bit rdy, input logic [7:0] d);
        tx_data_rdy = rdy;
        tx_data     = d;
        @(posedge clk);
        model_edge(rdy, d);
        @(negedge clk);
        tx_data_rdy = 1'b0;
        compare_all();
    endtask

    task automatic drain();
        int k = 0;
        while ((mq.size() != 0 || m_t <= m_fe) && k < 5000) begin
            cyc(1'b0, 8'h00);
            k++;
        end
        repeat (3) cyc(1'b0, 8'h00);
    endtask

    // Independent line receiver, sampling mid-bit.
    initial begin
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (rx_on && txd === 1'b0) begin
                rx_busy = 1'b1;
                repeat (BD / 2) @(negedge clk);
                chk("rx_start", txd, 1'b0);
                for (int i = 0; i < 8; i++) begin
                    repeat (BD) @(negedge clk);
                    b[i] = txd;
                end
                repeat (BD) @(negedge clk);
                chk("rx_stop", txd, 1'b1);
                rx_q.push_back(b);
                rx_busy = 1'b0;
            end
        end
    end

    initial begin
        #5_000_000;
        bad++;
        $display("FAIL watchdog at %0t", $time);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        logic [7:0] lb [4];
        logic [7:0] v;
        int         p, k;
        lb = '{8'h00, 8'hFF, 8'h5A, 8'hC3};
        rst_n = 1'b0; rx_on = 1'b0; rx_busy = 1'b0;
        d_rdy = 1'b0; d_data = 8'h00;
        m_t = 0;
        model_reset();
        tx_data_rdy = 1'b1;        // must be ignored while in reset
        tx_data     = 8'h99;
        repeat (3) @(negedge clk);
        chk("rst_txd",   txd,   1'b1);
        chk("rst_busy",  busy,  1'b0);
        chk("rst_count", count, 3'd0);
        chk("rst_full",  full,  1'b0);
        chk("rst_ovf",   ovf,   1'b0);
        chk("rst_def",   {d_txd, d_busy, d_full, d_ovf, d_count}, {4'b1000, 3'd0});
        tx_data_rdy = 1'b0;
        rst_n = 1'b1;
        compare_all();

        cyc(1'b1, 8'hA5);
        drain();

        for (int i = 1; i <= 6; i++) cyc(1'b1, 8'(i));
        drain();

        for (int i = 0; i < 5; i++) cyc(1'b1, 8'(8'h10 + i));
        k = 0;
        while (m_t != m_fe && k < 200) begin cyc(1'b0, 8'h00); k++; end
        chk("fullpop_pre", count, 3'd4);
        cyc(1'b1, 8'hE7);
        chk("fullpop_cnt", count, 3'd4);
        chk("fullpop_ovf", ovf,   1'b0);
        drain();

        rx_q.delete(); exp_rx.delete();
        rx_on = 1'b1;
        for (int i = 0; i < 4; i++) cyc(1'b1, lb[i]);
        drain();
        k = 0;
        while (rx_busy && k < 50) begin cyc(1'b0, 8'h00); k++; end
        rx_on = 1'b0;
        chk("rx_n", rx_q.size(), 4);
        for (int i = 0; i < 4; i++)
            chk("rx_byte", (i < rx_q.size()) ? rx_q[i] : 8'hxx, lb[i]);
        chk("rx_model_n", exp_rx.size(), 4);

        for (int i = 0; i < 1500; i++) begin
            p = ((i / 300) % 2 == 1) ? 60 : 3;
            cyc($urandom_range(0, 99) < p, 8'($urandom));
        end
        drain();

        cyc(1'b1, 8'h77);
        k = 0;
        while (m_t != m_fs + 4 * BD + 3 && k < 200) begin cyc(1'b0, 8'h00); k++; end
        cyc(1'b1, 8'h42);          // keep a byte queued behind the frame
        #2 rst_n = 1'b0;
        #1;
        chk("mid_txd",   txd,   1'b1);
        chk("mid_count", count, 3'd0);
        chk("mid_busy",  busy,  1'b0);
        chk("mid_full",  full,  1'b0);
        tx_data_rdy = 1'b1;
        tx_data     = 8'h11;
        repeat (2) @(posedge clk);
        @(negedge clk);
        tx_data_rdy = 1'b0;
        rst_n = 1'b1;
        model_reset();
        compare_all();
        repeat (5) cyc(1'b0, 8'h00);
        cyc(1'b1, 8'h3C);
        drain();

        v = 8'h55;
        d_data = v;
        d_rdy  = 1'b1;
        @(negedge clk);
        d_rdy  = 1'b0;
        for (int j = 1; j <= 10852; j++) begin
            if (j == 1) chk("def_idle", d_txd, 1'b1);
            if (j >= 2 && j <= 10851) begin
                k = j - 2;
                if ((k % DEF_BD) == 0 || (k % DEF_BD) == DEF_BD - 1) begin
                    p = k / DEF_BD;
                    chk("def_bit", d_txd, (p == 0) ? 1'b0 : (p == 9) ? 1'b1 : v[p-1]);
                end
            end
            if (j == 10851) chk("def_busy_end", d_busy, 1'b1);
            if (j == 10852) begin
                chk("def_busy_drop", d_busy, 1'b0);
                chk("def_line_idle", d_txd,  1'b1);
            end
            @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
